// File: rtl/car_sequencer.sv
// car_sequencer: control address register (CAR) microsequencer.
// Holds the control-store address and steps through microcode under
// control of the current microword's sequencing field. It also admits
// interrupts only at instruction boundaries.
//
// Build option: CARSEQ_ILLEGAL_TRAP_EN
//   defined   - an undefined instruction (car_in == 0) pulses illegal_op
//               and enters microcode at CAR_INT0.
//   undefined - an undefined instruction retires as a NOP.
//
// Ports:
//   clk, rst     system clock, async active-high reset
//   car_in       decoded microsequence index (0 = undefined instruction)
//   uc_seq       sequencing field: 00 NEXT, 01 DISPATCH, 10 FETCH, 11 HOLD
//   stall        memory wait; freezes all state and masks pulses
//   irq, gie     level interrupt request and global enable
//   car          registered control-store address
//   ir_load      instruction register load strobe
//   int_ack      interrupt acknowledge pulse
//   illegal_op   undefined-instruction pulse (trap build only)
//   retire       instruction-complete pulse
//   seq_err      sticky sequencing-error flag
//   retired_cnt  wrapping count of retired instructions
//
// state      | meaning
// -----------+-------------------------------------------------------
// S_FETCH    | car at fetch word; load IR or take a pending interrupt
// S_DISPATCH | IW settling through decoder; jump to its microsequence
// S_EXEC     | run microcode as directed by uc_seq
// S_INT      | acknowledge interrupt; jump to interrupt-entry microcode

module car_sequencer #(
    parameter int                     CAR_BITS  = 6,
    parameter logic [CAR_BITS-1:0]    CAR_FETCH = '0,
    parameter logic [CAR_BITS-1:0]    CAR_INT0  = CAR_BITS'(6'h3C)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CAR_BITS-1:0] car_in,
    input  logic [1:0]          uc_seq,
    input  logic                stall,
    input  logic                irq,
    input  logic                gie,
    output logic [CAR_BITS-1:0] car,
    output logic                ir_load,
    output logic                int_ack,
    output logic                illegal_op,
    output logic                retire,
    output logic                seq_err,
    output logic [15:0]         retired_cnt
);

    typedef enum logic [1:0] {
        S_FETCH    = 2'd0,
        S_DISPATCH = 2'd1,
        S_EXEC     = 2'd2,
        S_INT      = 2'd3
    } state_t;

    localparam logic [1:0] SEQ_NEXT     = 2'b00;
    localparam logic [1:0] SEQ_DISPATCH = 2'b01;
    localparam logic [1:0] SEQ_FETCH    = 2'b10;
    localparam logic [1:0] SEQ_HOLD     = 2'b11;

    state_t              state, state_nxt;
    logic [CAR_BITS-1:0] car_nxt;
    logic                err_nxt;
    logic                ir_load_c, int_ack_c, retire_c;
    logic                live;
`ifdef CARSEQ_ILLEGAL_TRAP_EN
    logic                illegal_c;
`endif

    assign live = ~stall & ~rst;

    always_comb begin
        state_nxt = state;
        car_nxt   = car;
        err_nxt   = seq_err;
        ir_load_c = 1'b0;
        int_ack_c = 1'b0;
        retire_c  = 1'b0;
`ifdef CARSEQ_ILLEGAL_TRAP_EN
        illegal_c = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                // Interrupts are only taken here, so a sequence is never split.
                if (irq && gie) begin
                    state_nxt = S_INT;
                end else begin
                    ir_load_c = 1'b1;
                    state_nxt = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (car_in != '0) begin
                    car_nxt   = car_in;
                    state_nxt = S_EXEC;
                end else begin
`ifdef CARSEQ_ILLEGAL_TRAP_EN
                    illegal_c = 1'b1;
                    car_nxt   = CAR_INT0;
                    state_nxt = S_EXEC;
`else
                    retire_c  = 1'b1;
                    car_nxt   = CAR_FETCH;
                    state_nxt = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                case (uc_seq)
                    SEQ_NEXT: begin
                        // Running off the end of the control store aborts
                        // the instruction without retiring it.
                        if (&car) begin
                            car_nxt   = CAR_FETCH;
                            state_nxt = S_FETCH;
                            err_nxt   = 1'b1;
                        end else begin
                            car_nxt = car + 1'b1;
                        end
                    end
                    SEQ_FETCH: begin
                        retire_c  = 1'b1;
                        car_nxt   = CAR_FETCH;
                        state_nxt = S_FETCH;
                    end
                    SEQ_DISPATCH: begin
                        retire_c  = 1'b1;
                        car_nxt   = CAR_FETCH;
                        state_nxt = S_FETCH;
                        err_nxt   = 1'b1;
                    end
                    SEQ_HOLD: ;
                    default: ;
                endcase
            end
            S_INT: begin
                int_ack_c = 1'b1;
                car_nxt   = CAR_INT0;
                state_nxt = S_EXEC;
            end
            default: begin
                car_nxt   = CAR_FETCH;
                state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            car         <= CAR_FETCH;
            seq_err     <= 1'b0;
            retired_cnt <= 16'h0000;
        end else if (!stall) begin
            state   <= state_nxt;
            car     <= car_nxt;
            seq_err <= err_nxt;
            if (retire_c) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
        end
    end

    assign ir_load = ir_load_c & live;
    assign int_ack = int_ack_c & live;
    assign retire  = retire_c  & live;
`ifdef CARSEQ_ILLEGAL_TRAP_EN
    assign illegal_op = illegal_c & live;
`else
    assign illegal_op = 1'b0;
`endif

endmodule
